// File: rtl/lcplc_pkg.sv
// Shared types and fixed-point helpers for the alpha prediction datapath.
package lcplc_pkg;

    typedef enum logic {
        PARAM,
        STREAM
    } state_e;

    localparam int unsigned ALPHA_WIDTH_DFLT = 10;

    function automatic int unsigned alpha_frac_bits(input int unsigned alpha_width);
        return alpha_width - 1;
    endfunction

    // Half an LSB of the fractional part: makes the arithmetic shift round half up.
    function automatic int unsigned round_offset(input int unsigned alpha_width);
        return 32'd1 << (alpha_width - 2);
    endfunction

endpackage

// File: rtl/pred_mac_stage.sv
// Two-stage multiply / round / clamp pipeline; xmean and last ride along with each sample.
module pred_mac_stage
    import lcplc_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = ALPHA_WIDTH_DFLT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] xhat_i,
    input  logic [DW-1:0] xhatmean_i,
    input  logic [AW-1:0] alpha_i,
    input  logic [DW-1:0] xmean_i,
    input  logic          last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o
);

    localparam int unsigned FRAC = alpha_frac_bits(AW);
    localparam int unsigned SW   = DW + AW + 2;
    localparam logic signed [SW-1:0] RND = SW'(round_offset(AW));

    logic                 s1_valid_q;
    logic signed [SW-1:0] s1_prod_q;
    logic [DW-1:0]        s1_xmean_q;
    logic                 s1_last_q;
    logic                 s2_valid_q;
    logic [DW-1:0]        s2_data_q;
    logic                 s2_last_q;

    logic                 adv1, adv2;
    logic signed [DW:0]   diff;
    logic signed [SW-1:0] diff_x, alpha_x, prod_full;
    logic signed [SW-1:0] rnd, shifted, sum;
    logic [DW-1:0]        clamped;

    assign adv2       = !s2_valid_q || out_ready_i;
    assign adv1       = !s1_valid_q || adv2;
    assign in_ready_o = adv1;

    always_comb begin
        diff      = $signed({1'b0, xhat_i}) - $signed({1'b0, xhatmean_i});
        diff_x    = {{(SW-DW-1){diff[DW]}}, diff};
        alpha_x   = $signed({{(SW-AW){1'b0}}, alpha_i});
        prod_full = diff_x * alpha_x;
    end

    always_comb begin
        rnd     = s1_prod_q + RND;
        shifted = rnd >>> FRAC;
        sum     = shifted + $signed({{(SW-DW){1'b0}}, s1_xmean_q});
        if (sum[SW-1]) begin
            clamped = '0;
        end else if (|sum[SW-2:DW]) begin
            clamped = '1;
        end else begin
            clamped = sum[DW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_xmean_q <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    s1_prod_q  <= prod_full;
                    s1_xmean_q <= xmean_i;
                    s1_last_q  <= last_i;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= clamped;
                    s2_last_q <= s1_last_q;
                end
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_last_o  = s2_last_q;

endmodule

// File: rtl/alpha_predictor.sv
// Per-block parameter capture (joint alpha/xmean/xhatmean handshake) feeding the prediction pipeline.
module alpha_predictor
    import lcplc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MAX_SIZE_LOG = 8,
    parameter int unsigned ALPHA_WIDTH  = ALPHA_WIDTH_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alpha_valid,
    output logic                   alpha_ready,
    input  logic [ALPHA_WIDTH-1:0] alpha_data,
    input  logic                   xmean_valid,
    output logic                   xmean_ready,
    input  logic [DATA_WIDTH-1:0]  xmean_data,
    input  logic                   xhatmean_valid,
    output logic                   xhatmean_ready,
    input  logic [DATA_WIDTH-1:0]  xhatmean_data,
    input  logic                   xhat_valid,
    output logic                   xhat_ready,
    input  logic [DATA_WIDTH-1:0]  xhat_data,
    input  logic                   xhat_last_s,
    output logic                   prediction_valid,
    input  logic                   prediction_ready,
    output logic [DATA_WIDTH-1:0]  prediction_data,
    output logic                   prediction_last
);

    state_e                  state_q, state_d;
    logic [ALPHA_WIDTH-1:0]  alpha_q, alpha_d;
    logic [DATA_WIDTH-1:0]   xmean_q, xmean_d;
    logic [DATA_WIDTH-1:0]   xhatmean_q, xhatmean_d;
    logic [MAX_SIZE_LOG-1:0] cnt_q, cnt_d;

    logic params_fire, mac_in_valid, mac_in_ready, xhat_fire, blk_last;

    // Readies are gated by rst so nothing looks accepted while reset is held.
    assign params_fire    = (state_q == PARAM) && !rst
                            && alpha_valid && xmean_valid && xhatmean_valid;
    assign alpha_ready    = params_fire;
    assign xmean_ready    = params_fire;
    assign xhatmean_ready = params_fire;

    assign mac_in_valid = (state_q == STREAM) && xhat_valid;
    assign xhat_ready   = (state_q == STREAM) && mac_in_ready;
    assign xhat_fire    = xhat_valid && xhat_ready;
    assign blk_last     = xhat_last_s || (cnt_q == '1);

    always_comb begin
        state_d    = state_q;
        alpha_d    = alpha_q;
        xmean_d    = xmean_q;
        xhatmean_d = xhatmean_q;
        cnt_d      = cnt_q;
        case (state_q)
            PARAM: begin
                if (params_fire) begin
                    alpha_d    = alpha_data;
                    xmean_d    = xmean_data;
                    xhatmean_d = xhatmean_data;
                    cnt_d      = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (xhat_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (blk_last) begin
                        state_d = PARAM;
                    end
                end
            end
            default: state_d = PARAM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PARAM;
            alpha_q    <= '0;
            xmean_q    <= '0;
            xhatmean_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alpha_q    <= alpha_d;
            xmean_q    <= xmean_d;
            xhatmean_q <= xhatmean_d;
            cnt_q      <= cnt_d;
        end
    end

    pred_mac_stage #(
        .DW (DATA_WIDTH),
        .AW (ALPHA_WIDTH)
    ) u_mac (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (mac_in_valid),
        .in_ready_o  (mac_in_ready),
        .xhat_i      (xhat_data),
        .xhatmean_i  (xhatmean_q),
        .alpha_i     (alpha_q),
        .xmean_i     (xmean_q),
        .last_i      (blk_last),
        .out_valid_o (prediction_valid),
        .out_ready_i (prediction_ready),
        .out_data_o  (prediction_data),
        .out_last_o  (prediction_last)
    );

endmodule

// File: tb/tb_alpha_predictor.sv
// Directed bench for alpha_predictor: hand-computed vectors plus a backpressured multi-block run.
`timescale 1ns/1ps
module tb_alpha_predictor;

    logic        clk;
    logic        rst;
    logic        alpha_valid, alpha_ready;
    logic [9:0]  alpha_data;
    logic        xmean_valid, xmean_ready;
    logic [15:0] xmean_data;
    logic        xhatmean_valid, xhatmean_ready;
    logic [15:0] xhatmean_data;
    logic        xhat_valid, xhat_ready;
    logic [15:0] xhat_data;
    logic        xhat_last_s;
    logic        prediction_valid, prediction_ready;
    logic [15:0] prediction_data;
    logic        prediction_last;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int n_timeout = 0;
    bit prod_done = 0;

    logic [16:0] got[$];
    logic [16:0] exp_q[$];

    alpha_predictor #(
        .DATA_WIDTH   (16),
        .MAX_SIZE_LOG (8),
        .ALPHA_WIDTH  (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alpha_valid      (alpha_valid),
        .alpha_ready      (alpha_ready),
        .alpha_data       (alpha_data),
        .xmean_valid      (xmean_valid),
        .xmean_ready      (xmean_ready),
        .xmean_data       (xmean_data),
        .xhatmean_valid   (xhatmean_valid),
        .xhatmean_ready   (xhatmean_ready),
        .xhatmean_data    (xhatmean_data),
        .xhat_valid       (xhat_valid),
        .xhat_ready       (xhat_ready),
        .xhat_data        (xhat_data),
        .xhat_last_s      (xhat_last_s),
        .prediction_valid (prediction_valid),
        .prediction_ready (prediction_ready),
        .prediction_data  (prediction_data),
        .prediction_last  (prediction_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (!rst && prediction_valid && prediction_ready)
            got.push_back({prediction_last, prediction_data});
    end

    function automatic int model(input int a, input int xm, input int xhm, input int x);
        int p, r, s;
        p = (x - xhm) * a;
        r = (p + 256) >>> 9;
        s = xm + r;
        if (s < 0) return 0;
        if (s > 65535) return 65535;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_params(input int a, input int xm, input int xhm);
        bit ok;
        ok = 0;
        @(negedge clk);
        alpha_data = 10'(a); xmean_data = 16'(xm); xhatmean_data = 16'(xhm);
        alpha_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #4;
            if (alpha_ready && xmean_ready && xhatmean_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else n_timeout++;
        #1;
        alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
    endtask

    task automatic send_xhat(input int d, input logic l);
        bit ok;
        ok = 0;
        @(negedge clk);
        xhat_data = 16'(d); xhat_last_s = l; xhat_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #4;
            if (xhat_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else n_timeout++;
        #1;
        xhat_valid = 1'b0; xhat_last_s = 1'b0;
    endtask

    task automatic wait_outputs(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(tag, got.size(), n);
    endtask

    task automatic expect_pred(input string tag, input int d, input logic l);
        logic [31:0] obs;
        obs = (got.size() > 0) ? {15'd0, got.pop_front()} : 32'hFFFF_FFFF;
        check(tag, obs, {15'd0, l, 16'(d)});
    endtask

    initial begin
        int pre, bad_d, bad_l, x, e;
        logic [16:0] g, ev;

        rst = 1'b1;
        alpha_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1;
        alpha_data = 10'd512; xmean_data = 16'd1; xhatmean_data = 16'd2;
        xhat_valid = 1'b0; xhat_data = '0; xhat_last_s = 1'b0;
        prediction_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pred_valid", prediction_valid, 0);
        check("rst_pred_data", prediction_data, 0);
        check("rst_pred_last", prediction_last, 0);
        check("rst_param_ready", {alpha_ready, xmean_ready, xhatmean_ready}, 0);
        check("rst_xhat_ready", xhat_ready, 0);
        @(negedge clk);
        alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
        rst = 1'b0;

        // alpha = 1.0: prediction is xmean + (xhat - xhatmean)
        send_params(512, 200, 100);
        send_xhat(150, 0);
        check("lat_stage1_not_valid", prediction_valid, 0);
        @(posedge clk);
        #1;
        check("lat_stage2_valid", prediction_valid, 1);
        send_xhat(100, 0);
        send_xhat(50, 1);
        wait_outputs("t1_count", 3, 50);
        expect_pred("t1_p0", 250, 0);
        expect_pred("t1_p1", 200, 0);
        expect_pred("t1_p2", 150, 1);

        // alpha = 0.5 rounding; stray last with valid low must be ignored
        send_params(256, 0, 0);
        @(negedge clk);
        xhat_last_s = 1'b1;
        repeat (3) @(negedge clk);
        xhat_last_s = 1'b0;
        send_xhat(3, 0);
        send_xhat(1, 1);
        send_params(256, 0, 6);
        send_xhat(3, 1);
        wait_outputs("t2_count", 3, 50);
        expect_pred("t2_half_up", 2, 0);
        expect_pred("t2_half", 1, 1);
        expect_pred("t2_floor0", 0, 1);

        // clamping at both rails
        send_params(1023, 10, 1010);
        send_xhat(10, 1);
        send_params(512, 65000, 0);
        send_xhat(1000, 1);
        wait_outputs("t3_count", 2, 50);
        expect_pred("t3_clamp_lo", 0, 1);
        expect_pred("t3_clamp_hi", 65535, 1);

        // partial parameter set is never consumed
        @(negedge clk);
        alpha_data = 10'd512; xhatmean_data = 16'd0; xmean_data = 16'd300;
        alpha_valid = 1'b1; xhatmean_valid = 1'b1; xmean_valid = 1'b0;
        pre = 0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (alpha_ready || xmean_ready || xhatmean_ready) pre++;
            @(negedge clk);
        end
        check("t4_partial_no_ready", pre, 0);
        xmean_valid = 1'b1;
        #4;
        check("t4_joint_ready", {alpha_ready, xmean_ready, xhatmean_ready}, 3'b111);
        @(posedge clk);
        #4;
        check("t4_single_handshake", {alpha_ready, xmean_ready, xhatmean_ready}, 0);
        alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
        send_xhat(25, 1);
        wait_outputs("t4_count", 1, 50);
        expect_pred("t4_pred", 325, 1);

        // four forced-termination blocks of 256 under random backpressure
        got.delete();
        exp_q.delete();
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    send_params(300 + 150 * b, 1000 * b + 500, 2000);
                    for (int i = 0; i < 256; i++) begin
                        x = (i * 251 + b * 77) % 5000;
                        e = model(300 + 150 * b, 1000 * b + 500, 2000, x);
                        exp_q.push_back({(i == 255), 16'(e)});
                        send_xhat(x, 0);
                    end
                end
                prod_done = 1;
            end
            begin
                while (!prod_done) begin
                    @(negedge clk);
                    prediction_ready = 1'($urandom_range(0, 1));
                end
                prediction_ready = 1'b1;
            end
        join
        wait_outputs("bp_count", 1024, 20000);
        bad_d = 0;
        bad_l = 0;
        for (int i = 0; i < 1024; i++) begin
            ev = exp_q[i];
            g = (i < got.size()) ? got[i] : ~ev;
            if (g[15:0] !== ev[15:0]) bad_d++;
            if (g[16] !== ev[16]) bad_l++;
        end
        check("bp_data_mismatches", bad_d, 0);
        check("bp_last_mismatches", bad_l, 0);
        got.delete();

        // async reset with two samples in flight
        prediction_ready = 1'b0;
        send_params(512, 1000, 0);
        send_xhat(5, 0);
        send_xhat(6, 0);
        @(negedge clk);
        check("hold_valid", prediction_valid, 1);
        check("hold_data0", prediction_data, 1005);
        @(negedge clk);
        check("hold_data1", {prediction_last, prediction_data}, {1'b0, 16'd1005});
        alpha_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", prediction_valid, 0);
        check("arst_data_last", {prediction_last, prediction_data}, 0);
        check("arst_readies", {alpha_ready, xmean_ready, xhatmean_ready, xhat_ready}, 0);
        @(negedge clk);
        alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0;
        rst = 1'b0;
        prediction_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("arst_no_stale", got.size(), 0);
        send_params(512, 0, 0);
        send_xhat(7, 1);
        wait_outputs("arst_count", 1, 50);
        expect_pred("arst_fresh", 7, 1);
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_extra", got.size(), 0);

        check("no_timeouts", n_timeout, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alpha_predictor.md
Name: alpha_predictor

Overview:
Consumer of the per-block alpha stream. For each block it takes alpha, the current-band mean (xmean) and the previous-band decoded mean (xhatmean). It then turns the previous-band decoded samples (xhat) into predicted samples using pred = xmean + alpha*(xhat - xhatmean), rounded and clamped. It is shared by the decoder's reconstruction path and the encoder's prediction feedback path. All interfaces are AXI-Stream style valid/ready.

Parameters:
DATA_WIDTH, 16, sample, mean and prediction width (unsigned)
MAX_SIZE_LOG, 8, log2 of the maximum samples per block
ALPHA_WIDTH, 10, alpha width; unsigned fixed point, value = alpha_data / 2^(ALPHA_WIDTH-1), range [0,2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
alpha_valid  in  1  alpha word valid
alpha_ready  out  1  alpha word accepted
alpha_data  in  ALPHA_WIDTH  per-block alpha
xmean_valid  in  1  current-band mean valid
xmean_ready  out  1  current-band mean accepted
xmean_data  in  DATA_WIDTH  current-band block mean
xhatmean_valid  in  1  previous-band mean valid
xhatmean_ready  out  1  previous-band mean accepted
xhatmean_data  in  DATA_WIDTH  previous-band decoded block mean
xhat_valid  in  1  decoded sample valid
xhat_ready  out  1  decoded sample accepted
xhat_data  in  DATA_WIDTH  previous-band decoded sample
xhat_last_s  in  1  marks the final sample of the block
prediction_valid  out  1  prediction valid
prediction_ready  in  1  downstream accepts the prediction
prediction_data  out  DATA_WIDTH  predicted sample
prediction_last  out  1  marks the final prediction of the block

Behaviour:
- Reset (asynchronous, any time including mid-block):
  - FSM goes to PARAM; all pipeline valids clear; sample counter = 0.
  - All ready outputs = 0, prediction_valid = 0, prediction_data = 0, prediction_last = 0.
  - In-flight data is discarded.
- FSM state PARAM:
  - alpha_ready, xmean_ready and xhatmean_ready are asserted together only when all three valids are high (joint handshake). A partial set is never consumed.
  - On the joint handshake, latch the three values, counter = 0, go to STREAM.
  - xhat_ready = 0 in this state.
- FSM state STREAM:
  - xhat_ready = stage-1 advance enable.
  - Each accepted xhat enters the pipeline tagged with the latched xmean and a last flag.
  - last flag = xhat_last_s OR (counter == 2^MAX_SIZE_LOG - 1); a block is force-terminated at its maximum size.
  - Counter increments per accepted sample.
  - Accepting a last sample returns the FSM to PARAM in the next cycle. Next-block parameters may be latched while the pipeline drains, because each stage carries its own xmean copy.
- Pipeline (2 stages):
  - Stage 1: diff = signed(xhat) - signed(xhatmean), DATA_WIDTH+1 bits; prod = diff * alpha, DATA_WIDTH+ALPHA_WIDTH+1 bits signed.
  - Stage 2: r = (prod + 2^(ALPHA_WIDTH-2)) >>> (ALPHA_WIDTH-1), arithmetic shift, round-half-up; sum = xmean + r; clamp to [0, 2^DATA_WIDTH-1].
  - Stage 2 drives the prediction outputs directly from registers.
- Latency and flow control:
  - Latency is 2 cycles from the xhat handshake to prediction_valid with no backpressure; throughput is 1 sample/cycle.
  - A stage advances when it is empty or the stage downstream advances. prediction_ready low freezes both stages; no sample is lost or duplicated.
  - prediction_data and prediction_last are held stable while valid && !ready.
- Boundary cases:
  - One-sample block (last on the first sample) is supported.
  - Parameters arriving before the previous block has drained wait in PARAM, or are latched if already in PARAM.
  - xhat_last_s is ignored while xhat_valid = 0.

Decomposition:
- Shared package (lcplc_pkg), holding:
  - the FSM state enum {PARAM, STREAM};
  - the alpha fractional-bit constant (ALPHA_WIDTH-1);
  - the rounding-offset function.
- One sub-module, pred_mac_stage: the 2-stage multiply/round/clamp pipeline with valid/ready and sideband (xmean, last) passthrough. The top level holds the FSM, joint parameter handshake and counter.

Test Plan:
- alpha=512 (1.0), xhatmean=100, xmean=200, block xhat={150,100,50}, last on 3rd -> predictions {250,200,150}, prediction_last only on 150.
- alpha=256 (0.5), xhatmean=0, xmean=0, xhat={3,1}; then xhatmean=6, xhat=3 -> {2,1}; then -1 (diff -3 rounds to -1, floored at 0) -> output 0.
- Clamping: xmean=10, alpha=1023, xhatmean=1010, xhat=10 -> 0; xmean=65000, alpha=512, xhatmean=0, xhat=1000 -> 65535.
- Random backpressure (prediction_ready 50%) over 4 blocks of 256 with xhat_last_s never asserted -> 1024 outputs matching the golden model, prediction_last every 256th, FSM re-enters PARAM each time.
- alpha valid but xmean withheld 10 cycles -> no ready asserted on any parameter port until all three are valid, then a single joint handshake.
- rst asserted asynchronously mid-block with 2 samples in flight -> outputs 0 immediately, next block starts clean with counter 0 and no stale predictions.
